// File: rtl/lcd_char_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_char_driver
// Purpose  : HD44780-compatible 16x2 character LCD driver, 8-bit write-only
//            bus. Runs the power-on initialisation by itself, then accepts
//            one character or command per send/ready handshake. Tracks the
//            cursor column and inserts line-change commands at line ends.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   char_in    in   8  character code, or command byte when is_cmd=1
//   is_cmd     in   1  1 = command write (RS=0), 0 = data write (RS=1)
//   send       in   1  write request, sampled only while ready=1
//   ready      out  1  driver idle and able to accept a send
//   init_done  out  1  initialisation finished (sticky until reset)
//   lcd_data   out  8  LCD data bus
//   lcd_rs     out  1  LCD register select
//   lcd_rw     out  1  LCD read/write, always write
//   lcd_e      out  1  LCD enable strobe
// ============================================================================
module lcd_char_driver #(
   parameter int CLK_HZ         = 50_000_000,
   parameter int POWERON_US     = 20000,
   parameter int CMD_US         = 50,
   parameter int CLEAR_US       = 2000,
   parameter int SETUP_CYCLES   = 4,
   parameter int E_PULSE_CYCLES = 25,
   parameter int AUTO_WRAP      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] char_in,
   input  logic       is_cmd,
   input  logic       send,
   output logic       ready,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);

   localparam int CYC_PER_US  = CLK_HZ / 1_000_000;
   localparam int POWERON_CYC = CYC_PER_US * POWERON_US;
   localparam int CMD_CYC     = CYC_PER_US * CMD_US;
   localparam int CLEAR_CYC   = CYC_PER_US * CLEAR_US;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared down-phase counter serves every timed state, so it is sized
   // for the longest of them.
   localparam int CNT_MAX = max2(max2(POWERON_CYC, CLEAR_CYC),
                                 max2(max2(CMD_CYC, SETUP_CYCLES), E_PULSE_CYCLES));
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] POWERON_LAST = CNT_W'(POWERON_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST     = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST   = CNT_W'(CLEAR_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(E_PULSE_CYCLES - 1);

   localparam logic [2:0] INIT_LEN = 3'd7;

   typedef enum logic [2:0] {
      ST_POWERON = 3'd0,
      ST_INIT    = 3'd1,
      ST_IDLE    = 3'd2,
      ST_SETUP   = 3'd3,
      ST_PULSE   = 3'd4,
      ST_HOLD    = 3'd5,
      ST_WAIT    = 3'd6,
      ST_WRAP    = 3'd7
   } state_t;

   state_t           state;
   state_t           state_next;
   state_t           ret_state;    // where the write sub-sequence returns to
   logic [CNT_W-1:0] cnt;
   logic [2:0]       init_idx;
   logic [7:0]       byte_q;
   logic             rs_q;
   logic             long_wait;    // clear/home need the long post-write wait
   logic             e_q;
   logic             init_done_q;
   logic [5:0]       column;       // 0..15 line 1, 16..31 line 2, 32 transient

   // Write-request controls produced by the next-state logic
   logic             cnt_run;
   logic             load;
   logic [7:0]       load_byte;
   logic             load_rs;
   state_t           load_ret;
   logic             init_adv;
   logic             finish_init;
   logic             data_wraps;

   function automatic logic [7:0] init_rom(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0, 3'd1, 3'd2, 3'd3: b = 8'h38;
         3'd4:                   b = 8'h0C;
         3'd5:                   b = 8'h01;
         3'd6:                   b = 8'h06;
         default:                b = 8'h00;
      endcase
      return b;
   endfunction

   // Cursor column after writing byte b with register select rs.
   function automatic logic [5:0] col_update(input logic [5:0] col,
                                             input logic [7:0] b,
                                             input logic       rs);
      logic [5:0] r;
      r = col;
      if (rs) begin
         if (AUTO_WRAP != 0) r = col + 6'd1;
         else                r = {1'b0, col[4:0] + 5'd1};
      end else if ((b == 8'h01) || (b == 8'h02)) begin
         r = 6'd0;
      end else if (b[7]) begin
         // Set-DDRAM-address: line 1 is 0x00..0x0F, line 2 is 0x40..0x4F
         if (b[6:4] == 3'b000)      r = {2'b00, b[3:0]};
         else if (b[6:4] == 3'b100) r = {2'b01, b[3:0]};
      end
      return r;
   endfunction

   // A data write from column 15 or 31 lands on a line end.
   assign data_wraps = (AUTO_WRAP != 0) && ((column == 6'd15) || (column == 6'd31));

   always_comb begin
      state_next  = state;
      cnt_run     = 1'b0;
      load        = 1'b0;
      load_byte   = 8'h00;
      load_rs     = 1'b0;
      load_ret    = ST_IDLE;
      init_adv    = 1'b0;
      finish_init = 1'b0;
      case (state)
         ST_POWERON: begin
            cnt_run = 1'b1;
            if (cnt == POWERON_LAST) state_next = ST_INIT;
         end
         ST_INIT: begin
            if (init_idx == INIT_LEN) begin
               finish_init = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               load       = 1'b1;
               load_byte  = init_rom(init_idx);
               load_ret   = ST_INIT;
               init_adv   = 1'b1;
               state_next = ST_SETUP;
            end
         end
         ST_IDLE: begin
            if (send) begin
               load       = 1'b1;
               load_byte  = char_in;
               load_rs    = ~is_cmd;
               load_ret   = (!is_cmd && data_wraps) ? ST_WRAP : ST_IDLE;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            cnt_run = 1'b1;
            if (cnt == SETUP_LAST) state_next = ST_PULSE;
         end
         ST_PULSE: begin
            cnt_run = 1'b1;
            if (cnt == PULSE_LAST) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_run = 1'b1;
            if ((long_wait && (cnt == CLEAR_LAST)) || (!long_wait && (cnt == CMD_LAST)))
               state_next = ret_state;
         end
         ST_WRAP: begin
            // Column 32 means the second line just filled: go back to line 1.
            load       = 1'b1;
            load_byte  = (column == 6'd32) ? 8'h80 : 8'hC0;
            load_ret   = ST_IDLE;
            state_next = ST_SETUP;
         end
         default: begin
            state_next = ST_POWERON;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_POWERON;
         ret_state   <= ST_IDLE;
         cnt         <= '0;
         init_idx    <= 3'd0;
         byte_q      <= 8'h00;
         rs_q        <= 1'b0;
         long_wait   <= 1'b0;
         e_q         <= 1'b0;
         init_done_q <= 1'b0;
         column      <= 6'd0;
      end else begin
         state <= state_next;
         // Registered strobe: high exactly while the FSM sits in PULSE.
         e_q   <= (state_next == ST_PULSE);
         if (cnt_run && (state_next == state)) cnt <= cnt + CNT_W'(1);
         else                                  cnt <= '0;
         if (load) begin
            byte_q    <= load_byte;
            rs_q      <= load_rs;
            ret_state <= load_ret;
            long_wait <= !load_rs && ((load_byte == 8'h01) || (load_byte == 8'h02));
            column    <= col_update(column, load_byte, load_rs);
         end
         if (init_adv) init_idx <= init_idx + 3'd1;
         if (finish_init) begin
            init_done_q <= 1'b1;
            column      <= 6'd0;
         end
      end
   end

   assign ready     = (state == ST_IDLE);
   assign init_done = init_done_q;
   assign lcd_data  = byte_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_e     = e_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_char_driver
// Purpose  : Scoreboard bench for lcd_char_driver. Stimulus pushes the
//            expected LCD bus writes into a queue; a monitor pops and checks
//            them on every lcd_e pulse, along with pulse shape and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_char_driver;
   localparam int CLK_HZ     = 1_000_000;
   localparam int POWERON_US = 100;
   localparam int CMD_US     = 5;
   localparam int CLEAR_US   = 20;
   localparam int SETUP      = 2;
   localparam int PULSE      = 3;
   localparam int CMD_CYC    = CMD_US * (CLK_HZ / 1_000_000);
   localparam int CLEAR_CYC  = CLEAR_US * (CLK_HZ / 1_000_000);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] char_in = 8'h00;
   logic       is_cmd = 1'b0;
   logic       send = 1'b0;
   logic       ready, init_done, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];   // {byte, rs}
   int col = 0;            // reference cursor column

   always #5 clk = ~clk;

   lcd_char_driver #(
      .CLK_HZ(CLK_HZ), .POWERON_US(POWERON_US), .CMD_US(CMD_US),
      .CLEAR_US(CLEAR_US), .SETUP_CYCLES(SETUP), .E_PULSE_CYCLES(PULSE),
      .AUTO_WRAP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .char_in(char_in), .is_cmd(is_cmd),
      .send(send), .ready(ready), .init_done(init_done),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycles the driver stays busy for one bus write.
   function automatic int wcyc(input logic [7:0] b, input logic rs);
      return SETUP + PULSE + 1 + ((!rs && (b == 8'h01 || b == 8'h02)) ? CLEAR_CYC : CMD_CYC);
   endfunction

   // Reference model: expected bus writes and busy time for one request.
   task automatic model_issue(input logic [7:0] b, input logic c, output int cyc);
      int bi;
      bi = int'(b);
      exp_q.push_back({b, ~c});
      cyc = wcyc(b, ~c);
      if (!c) begin
         col++;
         if (col == 16) begin
            exp_q.push_back({8'hC0, 1'b0});
            cyc += 1 + wcyc(8'hC0, 1'b0);
         end else if (col == 32) begin
            exp_q.push_back({8'h80, 1'b0});
            cyc += 1 + wcyc(8'h80, 1'b0);
            col = 0;
         end
      end else if (bi == 1 || bi == 2) begin
         col = 0;
      end else if (bi >= 'h80 && bi <= 'h8F) begin
         col = bi - 'h80;
      end else if (bi >= 'hC0 && bi <= 'hCF) begin
         col = 16 + bi - 'hC0;
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic       prev_e = 1'b0;
   int         hi_cnt = 0;
   int         gap = 0;
   int         min_gap = 0;
   logic [7:0] pd1 = 8'h00, pd2 = 8'h00, e_byte = 8'h00;
   logic       prs1 = 1'b0, prs2 = 1'b0, e_rs = 1'b0;
   logic [8:0] exp_w;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e  = 1'b0;
         hi_cnt  = 0;
         gap     = 0;
         min_gap = 0;
      end else begin
         if (lcd_e && !prev_e) begin
            check("setup_data", 32'({pd2, pd1}), 32'({lcd_data, lcd_data}));
            check("setup_rs", 32'({prs2, prs1}), 32'({lcd_rs, lcd_rs}));
            check("write_gap", 32'(gap >= min_gap), 32'd1);
            e_byte = lcd_data;
            e_rs   = lcd_rs;
            hi_cnt = 1;
         end else if (lcd_e) begin
            hi_cnt++;
            check("pulse_data", 32'({lcd_data, lcd_rs}), 32'({e_byte, e_rs}));
         end else if (prev_e) begin
            check("e_width", 32'(hi_cnt), 32'(PULSE));
            check("hold_data", 32'({lcd_data, lcd_rs}), 32'({e_byte, e_rs}));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got byte 0x%0h rs %0b, expected no write", e_byte, e_rs);
               exp_w = {e_byte, e_rs};
            end else begin
               exp_w = exp_q.pop_front();
               check("write_byte", 32'(e_byte), 32'(exp_w[8:1]));
               check("write_rs", 32'(e_rs), 32'(exp_w[0]));
            end
            min_gap = 1 + SETUP + ((!exp_w[0] && (exp_w[8:1] == 8'h01 || exp_w[8:1] == 8'h02)) ? CLEAR_CYC : CMD_CYC);
            gap = 1;
         end else begin
            gap++;
         end
         pd2    = pd1;
         pd1    = lcd_data;
         prs2   = prs1;
         prs1   = lcd_rs;
         prev_e = lcd_e;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: ready got %b after %0d cycles, expected 1", name, ready, n);
      end
   endtask

   task automatic run_init();
      logic [7:0] ib [7];
      bit quiet, together;
      int n;
      ib = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      col = 0;
      for (int i = 0; i < 7; i++) exp_q.push_back({ib[i], 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1;
      repeat (POWERON_US) begin
         @(negedge clk);
         if (lcd_e !== 1'b0 || ready !== 1'b0) quiet = 0;
      end
      check("poweron_quiet", 32'(quiet), 32'd1);
      together = 1;
      n = 0;
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         if (ready !== init_done) together = 0;
      end
      check("init_ready", 32'(ready), 32'd1);
      check("ready_with_init_done", 32'(together), 32'd1);
      check("init_done", 32'(init_done), 32'd1);
      check("init_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_send(input logic [7:0] b, input logic c, input bit glitch);
      int exp_cyc, n;
      bit held;
      wait_ready("send_ready");
      char_in = b;
      is_cmd  = c;
      send    = 1'b1;
      model_issue(b, c, exp_cyc);
      @(negedge clk);
      check("ready_drop", 32'(ready), 32'd0);
      send = 1'b0;
      if (glitch) begin
         send    = 1'b1;
         char_in = ~b;
         is_cmd  = ~c;
      end
      n = 1;
      held = (lcd_data === b) && (lcd_rs === ~c);
      while (ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         send = 1'b0;
         if (ready !== 1'b1) begin
            n++;
            if (lcd_data !== b || lcd_rs !== ~c) held = 0;
         end
      end
      check("busy_cycles", 32'(n), 32'(exp_cyc));
      if (exp_cyc == wcyc(b, ~c)) check("busy_data_hold", 32'(held), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cyc, n, r;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_lcd_data", 32'(lcd_data), 32'h00);
      check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
      check("rst_lcd_e", 32'(lcd_e), 32'd0);

      run_init();

      // Single character
      do_send(8'h48, 1'b0, 1'b0);

      // Fill both lines from the home position: inserted 0xC0 then 0x80
      do_send(8'h01, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++)
         do_send(8'($urandom_range(32, 126)), 1'b0, (i % 7) == 3);

      // Mid-line-2 start, then clear
      do_send(8'hC5, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++)
         do_send(8'($urandom_range(32, 126)), 1'b0, 1'b0);
      do_send(8'h01, 1'b1, 1'b1);

      // send held high: one write per idle visit
      wait_ready("held_ready");
      char_in = 8'h41;
      is_cmd  = 1'b0;
      send    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) wait_ready("held_ready");
         model_issue(8'h41, 1'b0, cyc);
         @(negedge clk);
         check("held_ready_drop", 32'(ready), 32'd0);
         if (k == 2) send = 1'b0;
      end
      wait_ready("held_done");
      check("held_drained", 32'(exp_q.size()), 32'd0);

      // Random mix of characters and commands
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            6:       do_send(($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02, 1'b1, 1'b0);
            7:       do_send(8'h80 | 8'($urandom_range(0, 15)), 1'b1, 1'b0);
            8:       do_send(8'hC0 | 8'($urandom_range(0, 15)), 1'b1, 1'b0);
            9:       do_send(8'h80 | 8'($urandom_range(0, 127)), 1'b1, $urandom_range(0, 1) != 0);
            default: do_send(8'($urandom_range(32, 126)), 1'b0, $urandom_range(0, 1) != 0);
         endcase
      end

      // Reset in the middle of an E pulse
      wait_ready("rst_ready");
      b       = 8'h55;
      char_in = b;
      is_cmd  = 1'b0;
      send    = 1'b1;
      model_issue(b, 1'b0, cyc);
      @(negedge clk);
      send = 1'b0;
      n = 0;
      while (lcd_e !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached_pulse", 32'(lcd_e), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_e", 32'(lcd_e), 32'd0);
      check("async_rst_ready", 32'(ready), 32'd0);
      check("async_rst_init_done", 32'(init_done), 32'd0);
      check("async_rst_data", 32'(lcd_data), 32'h00);
      exp_q.delete();
      repeat (3) @(negedge clk);
      run_init();
      do_send(8'h5A, 1'b0, 1'b0);
      check("init_done_sticky", 32'(init_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation got stuck, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/lcd_char_driver.md
Name: lcd_char_driver

Overview:
- HD44780-compatible character LCD driver: 8-bit bus, write-only.
- Runs the power-on initialisation sequence on its own.
- Accepts one character or command per send/ready handshake from the upstream message sequencer.
- Generates lcd_rs/lcd_e/lcd_data timing, and tracks the cursor so text wraps automatically across a 16x2 display.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- POWERON_US, 20000, wait after reset before the first init write.
- CMD_US, 50, post-write wait for normal characters and commands.
- CLEAR_US, 2000, post-write wait for clear (0x01) and home (0x02).
- SETUP_CYCLES, 4, cycles RS/data are stable before E rises.
- E_PULSE_CYCLES, 25, E high width in cycles.
- AUTO_WRAP, 1, when 1, insert cursor-move commands at line ends.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  8  character code, or command byte when is_cmd=1.
- is_cmd  in  1  1 = command write (RS=0); 0 = data write (RS=1).
- send  in  1  request; sampled only when ready=1.
- ready  out  1  driver idle and able to accept a send.
- init_done  out  1  set after the init sequence completes; stays set until reset.
- lcd_data  out  8  LCD data bus.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  tied 0.
- lcd_e  out  1  enable strobe.

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: ready=0, init_done=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0, lcd_e=0, column=0, state=POWERON, all counters 0.
- Time constants:
  - Microsecond waits are converted to cycles as (CLK_HZ/1_000_000)*US.
  - Every counter is sized with $clog2 of its largest terminal count.
- States:
  - POWERON: count POWERON_US, then go to INIT.
  - INIT: issue the ROM sequence 0x38, 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0.
    - Each byte goes through the write sub-sequence below.
    - After the last byte: init_done=1, column=0, go to IDLE.
  - IDLE: ready=1. If send=1, latch char_in/is_cmd, drop ready on the next cycle, go to WRITE.
  - WRITE sub-sequence:
    - SETUP: drive lcd_data/lcd_rs, lcd_e=0, for SETUP_CYCLES.
    - PULSE: lcd_e=1 for E_PULSE_CYCLES.
    - HOLD: lcd_e=0 for 1 cycle, data unchanged.
    - WAIT: CLEAR_US if the byte is a command 0x01 or 0x02, otherwise CMD_US.
    - Then return to the caller state: INIT, WRAP or IDLE.
  - WRAP (AUTO_WRAP=1 only): entered after a data write leaves column at 16 or 32.
    - column 16: write command 0xC0.
    - column 32: write command 0x80 and set column=0.
    - Then go to IDLE.
- Column tracking:
  - Data write: column += 1.
  - Command 0x01 or 0x02: column=0.
  - Command 0x80|a: if a in 0x00..0x0F, column=a; if a in 0x40..0x4F, column=16+(a-0x40); other addresses leave column unchanged.
  - All other commands leave column unchanged.
  - With AUTO_WRAP=0, column wraps modulo 32 and no commands are inserted.
- Handshake:
  - ready is 1 only in IDLE.
  - send while ready=0 is ignored and not queued.
  - send held high across consecutive IDLE visits produces one write per IDLE visit.
  - ready is 0 throughout POWERON, INIT and WRAP.
- lcd_data and lcd_rs change only while lcd_e=0. They hold the last value in IDLE.
- Reset asserted mid-operation: outputs return to reset values immediately, and the full POWERON/INIT sequence repeats.

Test Plan:
All scenarios use CLK_HZ=1_000_000, POWERON_US=100, CMD_US=5, CLEAR_US=20, SETUP_CYCLES=2, E_PULSE_CYCLES=3.
- Reset release -> no lcd_e activity for 100 cycles. Then seven E pulses carrying 38,38,38,38,0C,01,06 with rs=0, each exactly 3 cycles high. The gap after 0x01 is >= 20 cycles. init_done and ready rise together after the last wait.
- After init, send char 'H' (0x48), is_cmd=0 -> ready low the next cycle, lcd_rs=1, lcd_data=0x48 stable 2 cycles before E and during the 3-cycle pulse. ready returns after 2+3+1+5 cycles.
- Send 16 data chars -> the 16th write is followed by an inserted 0xC0 command (rs=0) before ready returns. Continue to 32 chars -> 0x80 is inserted and column resets to 0.
- Send command 0xC5 then 11 chars -> an inserted 0x80 follows the 11th char. Send 0x01 -> post-write wait of 20 cycles and column resets to 0.
- Pulse send while ready=0 during a write -> no extra E pulse and no data change.
- Deassert rst_n during a PULSE -> lcd_e=0 and ready=0 asynchronously. The POWERON wait of 100 cycles and the full init sequence repeat.
